// File: rtl/ras_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ras_pkg
// Description : Shared widths, checkpoint layout and slot arithmetic for the
//               checkpointed return address stack.
// Revision    : 1.0 - initial release
// ============================================================================
package ras_pkg;

    localparam int RAS_WIDTH_DEF = 31;
    localparam int RAS_DEPTH_DEF = 16;
    localparam int RAS_NCKPT_DEF = 4;
    localparam int RAS_PTR_W_DEF = $clog2(RAS_DEPTH_DEF);
    localparam int RAS_OCC_W_DEF = RAS_PTR_W_DEF + 1;

    // Reference layout of one checkpoint at default sizes; the RTL builds
    // the parametric equivalent from its own WIDTH/DEPTH.
    typedef struct packed {
        logic [RAS_PTR_W_DEF-1:0] tosp;
        logic [RAS_OCC_W_DEF-1:0] occ;
        logic [RAS_WIDTH_DEF-1:0] top;
    } ras_ckpt_doc_t;

    // Number of slots from from_id up to (not including) to_id, modulo nslots.
    function automatic int ras_slot_dist(input int to_id, input int from_id, input int nslots);
        return (to_id - from_id + nslots) % nslots;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ras_ckpt_queue.sv
`default_nettype none
// ============================================================================
// Module      : ras_ckpt_queue
// Description : Circular snapshot queue with alloc at tail, commit at head and
//               flush-truncate back to a named slot.
// Revision    : 1.0 - initial release
// ============================================================================
module ras_ckpt_queue
    import ras_pkg::*;
#(
    parameter int NCKPT = 4,
    parameter int DW    = 36
) (
    input  logic                     clk,
    input  logic                     rst_ni,
    input  logic                     alloc,
    input  logic [DW-1:0]            wdata,
    input  logic                     commit,
    input  logic                     flush,
    input  logic [$clog2(NCKPT)-1:0] flush_id,
    output logic [DW-1:0]            rdata,
    output logic                     ready,
    output logic [$clog2(NCKPT)-1:0] tail_id
);

    localparam int c_id_w = $clog2(NCKPT);
    localparam int c_cw   = c_id_w + 1;

    logic [DW-1:0]     r_slot [NCKPT];
    logic [c_id_w-1:0] r_head;
    logic [c_id_w-1:0] r_tail;
    logic [c_cw-1:0]   r_cnt;

    logic              w_commit_ok;
    logic              w_alloc_ok;
    logic [c_id_w-1:0] w_head_inc;
    logic [c_id_w-1:0] w_head_n;

    assign ready       = (r_cnt < c_cw'(NCKPT));
    assign w_commit_ok = commit && (r_cnt != '0);
    assign w_alloc_ok  = alloc && ready && !flush;
    assign w_head_inc  = r_head + c_id_w'(1);
    assign w_head_n    = w_commit_ok ? w_head_inc : r_head;
    assign rdata       = r_slot[flush_id];
    assign tail_id     = r_tail;

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NCKPT; i++) r_slot[i] <= '0;
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= '0;
        end else if (flush) begin
            // Restoring the head while committing it leaves nothing live.
            if (w_commit_ok && (flush_id == r_head)) begin
                r_head <= w_head_inc;
                r_tail <= w_head_inc;
                r_cnt  <= '0;
            end else begin
                r_head <= w_head_n;
                r_tail <= flush_id;
                r_cnt  <= c_cw'(ras_slot_dist(int'(flush_id), int'(w_head_n), NCKPT));
            end
        end else begin
            if (w_alloc_ok) begin
                r_slot[r_tail] <= wdata;
                r_tail         <= r_tail + c_id_w'(1);
            end
            r_head <= w_head_n;
            r_cnt  <= r_cnt + c_cw'(w_alloc_ok) - c_cw'(w_commit_ok);
        end
    end

endmodule
`default_nettype wire

// File: rtl/ras_ckpt.sv
`default_nettype none
// ============================================================================
// Module      : ras_ckpt
// Description : Wrapping return address stack with checkpoint/restore for
//               mispredict recovery.
// Revision    : 1.0 - initial release
// ============================================================================
module ras_ckpt
    import ras_pkg::*;
#(
    parameter int WIDTH = RAS_WIDTH_DEF,
    parameter int DEPTH = RAS_DEPTH_DEF,
    parameter int NCKPT = RAS_NCKPT_DEF
) (
    input  logic                     clk,
    input  logic                     rst_ni,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     valid,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     ckpt_req,
    output logic                     ckpt_ready,
    output logic [$clog2(NCKPT)-1:0] ckpt_id,
    input  logic                     commit,
    input  logic                     flush,
    input  logic [$clog2(NCKPT)-1:0] flush_id
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_occ_w = c_ptr_w + 1;
    localparam int c_dw    = c_ptr_w + c_occ_w + WIDTH;
    localparam logic [c_occ_w-1:0] c_occ_full = c_occ_w'(DEPTH);

    typedef struct packed {
        logic [c_ptr_w-1:0] tosp;
        logic [c_occ_w-1:0] occ;
        logic [WIDTH-1:0]   top;
    } ckpt_t;

    logic               r_act;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_tosp;
    logic [c_occ_w-1:0] r_occ;
    logic               r_ovf;
    logic               r_unf;

    logic [c_ptr_w-1:0] w_tosp_n;
    logic [c_occ_w-1:0] w_occ_n;
    logic [WIDTH-1:0]   w_top_n;
    logic               w_we;
    logic [c_ptr_w-1:0] w_waddr;
    logic [WIDTH-1:0]   w_wdata;
    logic               w_ovf_n;
    logic               w_unf_n;
    logic [c_dw-1:0]    w_rd;
    ckpt_t              w_restore;
    ckpt_t              w_snap;

    // Ops are held off for the first edge after reset release.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) r_act <= 1'b0;
        else         r_act <= 1'b1;
    end

    assign w_restore = w_rd;

    always_comb begin
        w_tosp_n = r_tosp;
        w_occ_n  = r_occ;
        w_top_n  = r_mem[r_tosp];
        w_we     = 1'b0;
        w_waddr  = r_tosp;
        w_wdata  = din;
        w_ovf_n  = 1'b0;
        w_unf_n  = 1'b0;
        if (r_act) begin
            if (flush) begin
                w_tosp_n = w_restore.tosp;
                w_occ_n  = w_restore.occ;
                w_top_n  = w_restore.top;
                w_we     = 1'b1;
                w_waddr  = w_restore.tosp;
                w_wdata  = w_restore.top;
            end else if (push && pop) begin
                w_top_n = din;
                w_we    = 1'b1;
                if (r_occ == '0) w_occ_n = c_occ_w'(1);
            end else if (push) begin
                w_tosp_n = r_tosp + c_ptr_w'(1);
                w_top_n  = din;
                w_we     = 1'b1;
                w_waddr  = r_tosp + c_ptr_w'(1);
                if (r_occ == c_occ_full) w_ovf_n = 1'b1;
                else                     w_occ_n = r_occ + c_occ_w'(1);
            end else if (pop) begin
                if (r_occ != '0) begin
                    w_tosp_n = r_tosp - c_ptr_w'(1);
                    w_occ_n  = r_occ - c_occ_w'(1);
                    w_top_n  = r_mem[r_tosp - c_ptr_w'(1)];
                end else begin
                    w_unf_n = 1'b1;
                end
            end
        end
    end

    // Snapshot reflects this cycle's push/pop, i.e. the state after the edge.
    assign w_snap = '{tosp: w_tosp_n, occ: w_occ_n, top: w_top_n};

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_tosp <= '0;
            r_occ  <= '0;
            r_ovf  <= 1'b0;
            r_unf  <= 1'b0;
        end else begin
            if (w_we) r_mem[w_waddr] <= w_wdata;
            r_tosp <= w_tosp_n;
            r_occ  <= w_occ_n;
            r_ovf  <= w_ovf_n;
            r_unf  <= w_unf_n;
        end
    end

    ras_ckpt_queue #(
        .NCKPT (NCKPT),
        .DW    (c_dw)
    ) u_queue (
        .clk      (clk),
        .rst_ni   (rst_ni),
        .alloc    (r_act & ckpt_req & ~flush),
        .wdata    (w_snap),
        .commit   (r_act & commit),
        .flush    (r_act & flush),
        .flush_id (flush_id),
        .rdata    (w_rd),
        .ready    (ckpt_ready),
        .tail_id  (ckpt_id)
    );

    assign dout      = r_mem[r_tosp];
    assign valid     = (r_occ != '0);
    assign overflow  = r_ovf;
    assign underflow = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_ras_ckpt.sv
`default_nettype none
// ============================================================================
// Module      : tb_ras_ckpt
// Description : Self-checking bench for ras_ckpt against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ras_ckpt;

    localparam int W  = 31;
    localparam int D  = 16;
    localparam int N  = 4;
    localparam int IW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          push = 1'b0, pop = 1'b0, ckpt_req = 1'b0, commit = 1'b0, flush = 1'b0;
    logic [W-1:0]  din = '0;
    logic [IW-1:0] flush_id = '0;
    logic [W-1:0]  dout;
    logic          valid, overflow, underflow, ckpt_ready;
    logic [IW-1:0] ckpt_id;

    int errors = 0;
    int checks = 0;

    ras_ckpt #(.WIDTH(W), .DEPTH(D), .NCKPT(N)) dut (
        .clk(clk), .rst_ni(rst_ni), .push(push), .pop(pop), .din(din),
        .dout(dout), .valid(valid), .overflow(overflow), .underflow(underflow),
        .ckpt_req(ckpt_req), .ckpt_ready(ckpt_ready), .ckpt_id(ckpt_id),
        .commit(commit), .flush(flush), .flush_id(flush_id)
    );

    always #5 clk = ~clk;

    // Model: a circular array for the stack, a queue of live snapshots whose
    // front carries id m_head.
    typedef struct {
        int           tosp;
        int           occ;
        logic [W-1:0] top;
    } ck_t;

    logic [W-1:0] m_mem [D];
    int           m_tosp, m_occ, m_head;
    logic         exp_ovf, exp_unf;
    ck_t          ckq [$];

    function automatic logic [W-1:0] m_top();
        return m_mem[m_tosp];
    endfunction

    function automatic logic [IW-1:0] m_id();
        int v;
        v = (m_head + ckq.size()) % N;
        return v[IW-1:0];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < D; i++) m_mem[i] = '0;
        m_tosp = 0; m_occ = 0; m_head = 0;
        exp_ovf = 1'b0; exp_unf = 1'b0;
        ckq.delete();
    endtask

    task automatic cyc(input logic p, input logic po, input logic [W-1:0] d,
                       input logic rq, input logic cm, input logic fl, input int fid);
        int   sz, pos;
        logic cm_ok, al_ok;
        ck_t  c;
        @(negedge clk);
        push = p; pop = po; din = d; ckpt_req = rq; commit = cm; flush = fl;
        flush_id = fid[IW-1:0];
        @(posedge clk);
        sz = ckq.size();
        exp_ovf = 1'b0; exp_unf = 1'b0;
        if (fl) begin
            pos = (fid - m_head + N) % N;
            assert (pos < sz) else $error("protocol: flush_id %0d not live", fid);
            c = ckq[pos];
            m_tosp = c.tosp; m_occ = c.occ; m_mem[c.tosp] = c.top;
            while (ckq.size() > pos) void'(ckq.pop_back());
            if (cm) begin
                m_head = (m_head + 1) % N;
                if (ckq.size() > 0) void'(ckq.pop_front());
            end
        end else begin
            if (p && po) begin
                m_mem[m_tosp] = d;
                if (m_occ == 0) m_occ = 1;
            end else if (p) begin
                m_tosp = (m_tosp + 1) % D;
                m_mem[m_tosp] = d;
                if (m_occ < D) m_occ++; else exp_ovf = 1'b1;
            end else if (po) begin
                if (m_occ > 0) begin m_tosp = (m_tosp + D - 1) % D; m_occ--; end
                else exp_unf = 1'b1;
            end
            cm_ok = cm && (sz > 0);
            al_ok = rq && (sz < N);
            if (cm_ok) begin void'(ckq.pop_front()); m_head = (m_head + 1) % N; end
            if (al_ok) begin
                c.tosp = m_tosp; c.occ = m_occ; c.top = m_mem[m_tosp];
                ckq.push_back(c);
            end
        end
        #1;
        push = 0; pop = 0; ckpt_req = 0; commit = 0; flush = 0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        model_reset();
        @(posedge clk);
        release_reset();
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (dout !== '0) begin errors++; $display("FAIL reset_dout: got %0h want 0", dout); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL reset_flags: got %b%b want 00", overflow, underflow); end
        checks++; if (ckpt_ready !== 1'b1 || ckpt_id !== '0) begin errors++; $display("FAIL reset_ckpt: got ready=%b id=%0d want 1/0", ckpt_ready, ckpt_id); end
        // A push on the first edge after release must be ignored.
        @(negedge clk);
        rst_ni = 1'b1; push = 1'b1; din = 31'h5;
        @(posedge clk);
        #1;
        push = 1'b0;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL first_edge_ignored: got valid=%b want 0", valid); end
    endtask

    task automatic test_basic();
        cyc(1, 0, 31'h10, 0, 0, 0, 0);
        cyc(1, 0, 31'h20, 0, 0, 0, 0);
        cyc(1, 0, 31'h30, 0, 0, 0, 0);
        checks++; if (dout !== 31'h30 || valid !== 1'b1) begin errors++; $display("FAIL push3_top: got %0h/%b want 30/1", dout, valid); end
        cyc(0, 1, 0, 0, 0, 0, 0);
        checks++; if (dout !== 31'h20) begin errors++; $display("FAIL pop1: got %0h want 20", dout); end
        cyc(0, 1, 0, 0, 0, 0, 0);
        checks++; if (dout !== 31'h10) begin errors++; $display("FAIL pop2: got %0h want 10", dout); end
        cyc(0, 1, 0, 0, 0, 0, 0);
        checks++; if (valid !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL pop3_empty: got valid=%b unf=%b want 0/0", valid, underflow); end
        cyc(0, 1, 0, 0, 0, 0, 0);
        checks++; if (underflow !== 1'b1 || valid !== 1'b0) begin errors++; $display("FAIL underflow_pulse: got unf=%b valid=%b want 1/0", underflow, valid); end
        cyc(0, 0, 0, 0, 0, 0, 0);
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL underflow_once: got %b want 0", underflow); end
    endtask

    task automatic test_overflow();
        int n_ovf = 0;
        for (int i = 1; i <= 17; i++) begin
            cyc(1, 0, W'(i), 0, 0, 0, 0);
            if (overflow === 1'b1) n_ovf++;
            if (i == 17) begin
                checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_on_17: got %b want 1", overflow); end
            end
        end
        cyc(0, 0, 0, 0, 0, 0, 0);
        if (overflow === 1'b1) n_ovf++;
        checks++; if (n_ovf != 1) begin errors++; $display("FAIL overflow_count: got %0d want 1", n_ovf); end
        for (int i = 0; i < 16; i++) begin
            checks++; if (dout !== W'(17 - i)) begin errors++; $display("FAIL wrap_pop_%0d: got %0h want %0h", i, dout, 17 - i); end
            cyc(0, 1, 0, 0, 0, 0, 0);
        end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL wrap_empty: got valid=%b want 0", valid); end
    endtask

    task automatic test_flush_restore();
        do_reset();
        cyc(1, 0, 31'h0A5A, 0, 0, 0, 0);
        checks++; if (ckpt_id !== 2'd0) begin errors++; $display("FAIL ckpt_first_id: got %0d want 0", ckpt_id); end
        cyc(0, 0, 0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(1, 0, 31'h0B6B, 0, 0, 0, 0);
        checks++; if (dout !== 31'h0B6B) begin errors++; $display("FAIL spec_push_b: got %0h want b6b", dout); end
        cyc(0, 0, 0, 0, 0, 1, 0);
        checks++; if (dout !== 31'h0A5A || valid !== 1'b1) begin errors++; $display("FAIL flush_restore: got %0h/%b want a5a/1", dout, valid); end
        cyc(0, 1, 0, 0, 0, 0, 0);
        checks++; if (valid !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL flush_occ1: got valid=%b unf=%b want 0/0", valid, underflow); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0, 0, 0);
        checks++; if (ckpt_ready !== 1'b0 || ckpt_id !== 2'd0) begin errors++; $display("FAIL ckpt_full: got ready=%b id=%0d want 0/0", ckpt_ready, ckpt_id); end
        cyc(0, 0, 0, 1, 0, 0, 0);
        checks++; if (ckpt_ready !== 1'b0 || ckpt_id !== 2'd0) begin errors++; $display("FAIL ckpt_5th_ignored: got ready=%b id=%0d want 0/0", ckpt_ready, ckpt_id); end
        cyc(0, 0, 0, 0, 1, 0, 0);
        checks++; if (ckpt_ready !== 1'b1 || ckpt_id !== 2'd0) begin errors++; $display("FAIL commit_frees: got ready=%b id=%0d want 1/0", ckpt_ready, ckpt_id); end
    endtask

    task automatic test_flush_truncate();
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1, 0, W'(32'h100 + i), 1, 0, 0, 0);
        cyc(1, 0, 31'h999, 0, 0, 1, 1);
        checks++; if (dout !== 31'h101 || valid !== 1'b1) begin errors++; $display("FAIL trunc_restore: got %0h/%b want 101/1", dout, valid); end
        checks++; if (ckpt_id !== 2'd1 || ckpt_ready !== 1'b1) begin errors++; $display("FAIL trunc_tail: got id=%0d ready=%b want 1/1", ckpt_id, ckpt_ready); end
        cyc(0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0);
        checks++; if (ckpt_ready !== 1'b1) begin errors++; $display("FAIL trunc_cnt3: got ready=%b want 1", ckpt_ready); end
        cyc(0, 0, 0, 1, 0, 0, 0);
        checks++; if (ckpt_ready !== 1'b0) begin errors++; $display("FAIL trunc_cnt4: got ready=%b want 0", ckpt_ready); end
    endtask

    task automatic test_flush_commit();
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1, 0, W'(32'h200 + i), 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 1, 1);
        checks++; if (dout !== 31'h201) begin errors++; $display("FAIL fc_restore: got %0h want 201", dout); end
        checks++; if (ckpt_id !== 2'd2 || ckpt_ready !== 1'b1) begin errors++; $display("FAIL fc_empty: got id=%0d ready=%b want 2/1", ckpt_id, ckpt_ready); end
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0, 0, 0);
        checks++; if (ckpt_ready !== 1'b1) begin errors++; $display("FAIL fc_cnt3: got ready=%b want 1", ckpt_ready); end
        cyc(0, 0, 0, 1, 0, 0, 0);
        checks++; if (ckpt_ready !== 1'b0 || ckpt_id !== 2'd2) begin errors++; $display("FAIL fc_cnt4: got ready=%b id=%0d want 0/2", ckpt_ready, ckpt_id); end
    endtask

    task automatic test_random();
        logic p, po, rq, cm, fl;
        int   fid;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            p  = ($urandom_range(0, 99) < 45);
            po = ($urandom_range(0, 99) < 40);
            rq = ($urandom_range(0, 99) < 35);
            cm = ($urandom_range(0, 99) < 20);
            fl = ($urandom_range(0, 99) < 10) && (ckq.size() > 0);
            fid = fl ? (m_head + int'($urandom_range(0, ckq.size() - 1))) % N : 0;
            cyc(p, po, W'($urandom()), rq, cm, fl, fid);
            checks++; if (dout !== m_top()) begin errors++; $display("FAIL rnd_dout @%0d: got %0h want %0h", n, dout, m_top()); end
            checks++; if (valid !== (m_occ != 0)) begin errors++; $display("FAIL rnd_valid @%0d: got %b want %b", n, valid, m_occ != 0); end
            checks++; if (overflow !== exp_ovf || underflow !== exp_unf) begin errors++; $display("FAIL rnd_flags @%0d: got %b%b want %b%b", n, overflow, underflow, exp_ovf, exp_unf); end
            checks++; if (ckpt_ready !== (ckq.size() < N)) begin errors++; $display("FAIL rnd_ready @%0d: got %b want %b", n, ckpt_ready, ckq.size() < N); end
            checks++; if (ckpt_id !== m_id()) begin errors++; $display("FAIL rnd_id @%0d: got %0d want %0d", n, ckpt_id, m_id()); end
        end
    endtask

    task automatic test_reset_mid();
        cyc(1, 0, 31'h77, 1, 0, 0, 0);
        cyc(1, 0, 31'h78, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        #2;
        rst_ni = 1'b0;
        #1;
        checks++; if (dout !== '0 || valid !== 1'b0) begin errors++; $display("FAIL midreset_stack: got %0h/%b want 0/0", dout, valid); end
        checks++; if (ckpt_ready !== 1'b1 || ckpt_id !== '0 || overflow !== 1'b0 || underflow !== 1'b0) begin
            errors++; $display("FAIL midreset_ckpt: got ready=%b id=%0d ovf=%b unf=%b want 1/0/0/0", ckpt_ready, ckpt_id, overflow, underflow);
        end
        model_reset();
        release_reset();
        cyc(1, 0, 31'h42, 0, 0, 0, 0);
        checks++; if (dout !== 31'h42 || ckpt_id !== '0) begin errors++; $display("FAIL after_reset_push: got %0h id=%0d want 42/0", dout, ckpt_id); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_flush_restore();
        test_full();
        test_flush_truncate();
        test_flush_commit();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
